// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/ready handshake, operands and result of the bit-serial adder.
//   start, a, b              : driven by the requesting master
//   ready, busy, done, sum, cout : driven by the adder controller (slave)
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, input ready, busy, done, sum, cout);
    modport slave (input start, a, b, output ready, busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one result bit per clock through a half-adder pair.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_adder_ctrl_if (start/a/b in; ready/busy/done/sum/cout out)
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q, res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q, busy_q, done_q;
    logic             s0, c0, s1, c1, carry_d;
    half_adder ha0 (.a_i(a_q[0]), .b_i(b_q[0]), .s_o(s0), .c_o(c0));
    half_adder ha1 (.a_i(s0), .b_i(carry_q), .s_o(s1), .c_o(c1));
    assign carry_d = c0 | c1;
    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    assign res_d = (res_q >> 1) | (WIDTH'(s1) << (WIDTH - 1));
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= RUN;
                    a_q     <= bus.a;
                    b_q     <= bus.b;
                    carry_q <= 1'b0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.ready = state_q == IDLE;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table, random and corner-sequence checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_sum = '0;
    logic last_cout = 1'b0;
    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    serial_adder_ctrl_if #(.WIDTH(1)) w1 ();
    serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(w1));
    always #5 clk = ~clk;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic c;
    } vec_t;
    vec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] es,
                          input logic ec, input bit hold);
        int cyc;
        int nb;
        chk("ready_before", bus.ready, 1);
        bus.start = 1'b1;
        bus.a = ta;
        bus.b = tb_;
        step();
        if (hold) begin
            bus.a = 8'hAA;
            bus.b = 8'h55;
        end else begin
            bus.start = 1'b0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end
        chk("ready_run", bus.ready, 0);
        chk("hold_sum", bus.sum, last_sum);
        chk("hold_cout", bus.cout, last_cout);
        cyc = 0;
        nb = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nb++;
            step();
            cyc++;
        end
        chk("latency", cyc, W);
        chk("busy_cycles", nb, W);
        chk("sum", bus.sum, es);
        chk("cout", bus.cout, ec);
        chk("busy_done", bus.busy, 0);
        chk("ready_done", bus.ready, 0);
        last_sum = es;
        last_cout = ec;
        step();
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 0);
        chk("ready_after", bus.ready, 1);
    endtask

    initial begin
        logic [W-1:0] ra, rb, ca, cb;
        logic [W:0] m;
        int cyc, last_acc, ops, nd;
        logic pb;
        tbl[0] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{8'h01, 8'h02, 8'h03, 1'b0};
        bus.start = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        w1.start = 1'b0;
        w1.a = 1'b0;
        w1.b = 1'b0;
        step();
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);

        for (int i = 0; i < 5; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            m = {1'b0, ra} + {1'b0, rb};
            run_op(ra, rb, m[W-1:0], m[W], 1'b0);
        end

        run_op(8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("idle_hold_sum", bus.sum, 8'h30);
        run_op(8'h05, 8'h06, 8'h0B, 1'b0, 1'b0);

        bus.start = 1'b1;
        bus.a = 8'h77;
        bus.b = 8'h11;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", bus.ready, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_cout", bus.cout, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) nd++;
            step();
        end
        chk("midrst_no_done", nd, 0);
        last_sum = '0;
        last_cout = 1'b0;
        run_op(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        ca = W'($urandom);
        cb = W'($urandom);
        bus.start = 1'b1;
        bus.a = ca;
        bus.b = cb;
        pb = 1'b0;
        cyc = 0;
        last_acc = -1;
        ops = 0;
        while (ops < 4 && cyc < 200) begin
            step();
            cyc++;
            if (bus.busy && !pb) begin
                if (last_acc >= 0) chk("b2b_gap", cyc - last_acc, W + 2);
                last_acc = cyc;
            end
            if (bus.done) begin
                m = {1'b0, ca} + {1'b0, cb};
                chk("b2b_sum", bus.sum, m[W-1:0]);
                chk("b2b_cout", bus.cout, m[W]);
                ops++;
                ca = W'($urandom);
                cb = W'($urandom);
                bus.a = ca;
                bus.b = cb;
            end
            pb = bus.busy;
        end
        bus.start = 1'b0;
        chk("b2b_ops", ops, 4);
        step();
        step();

        w1.start = 1'b1;
        w1.a = 1'b1;
        w1.b = 1'b1;
        step();
        w1.start = 1'b0;
        chk("w1_busy", w1.busy, 1);
        step();
        chk("w1_done", w1.done, 1);
        chk("w1_sum_11", w1.sum, 0);
        chk("w1_cout_11", w1.cout, 1);
        step();
        chk("w1_ready", w1.ready, 1);
        w1.start = 1'b1;
        w1.a = 1'b1;
        w1.b = 1'b0;
        step();
        w1.start = 1'b0;
        step();
        chk("w1_done2", w1.done, 1);
        chk("w1_sum_10", w1.sum, 1);
        chk("w1_cout_10", w1.cout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
